// File: rtl/sd_file_stream_if.sv
// rtl/sd_file_stream_if.sv - byte-in / word-out stream bundle of sd_file_stream
interface sd_file_stream_if #(
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              in_en;
  logic [7:0]        in_byte;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NB-1:0]     out_keep;
  logic              out_last;

  // master is the packer side, slave is the reader/consumer side
  modport master (
    input  in_en, in_byte, out_ready,
    output out_valid, out_data, out_keep, out_last
  );
  modport slave (
    output in_en, in_byte, out_ready,
    input  out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/sd_file_stream.sv
// rtl/sd_file_stream.sv - sd_file_reader byte strobes to little-endian keep/last word stream
// Optional byte checksum on the sum port when SFS_SUM_EN is defined.
module sd_file_stream #(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int MAX_BYTES    = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             reader_rstn,
  input  logic             file_found,
  sd_file_stream_if.master strm,
  output logic [31:0]      byte_count,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [31:0]      sum
);
  localparam int NB = DATA_W / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + NB + 1;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DONE, ERR} state_t;

  state_t            state;
  logic              start_q;
  logic [31:0]       idle_cnt;
  logic [DATA_W-1:0] acc;
  logic [LW-1:0]     lane;
  logic              pend;
  logic              tail_done;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       fcount;
  logic [EW-1:0]     head;
  logic              fifo_empty;
  logic              fifo_full;

  logic              start_rise;
  logic              lim_hit;
  logic              accept;
  logic              need_tail;
  logic              pop;
  logic              run_push;
  logic              flush_push;
  logic              push;
  logic              ovf_hit;
  logic              wr_en;
  logic              fifo_clr;
  logic [NB-1:0]     part_keep;
  logic [NB-1:0]     push_keep;
  logic [31:0]       count_inc;
  logic              unused_file_found;

  assign unused_file_found = file_found;

  always_comb begin
    part_keep = '0;
    for (int k = 0; k < NB; k++)
      part_keep[k] = (k < int'(lane));
  end

  assign fifo_empty = (fcount == '0);
  assign fifo_full  = (fcount == (AW+1)'(FIFO_DEPTH));
  assign start_rise = start && !start_q;
  assign lim_hit    = (MAX_BYTES != 0) && (byte_count >= 32'(MAX_BYTES));
  assign accept     = (state == RUN) && start && strm.in_en && !lim_hit;
  assign need_tail  = (byte_count != '0) && !tail_done;
  assign pop        = !fifo_empty && strm.out_ready;
  // A completed word waits in acc until the next byte proves it is not the last one
  assign run_push   = accept && pend;
  assign flush_push = (state == FLUSH) && start && need_tail && !fifo_full;
  assign push       = run_push || flush_push;
  assign ovf_hit    = run_push && fifo_full && !pop;
  assign wr_en      = push && !ovf_hit;
  assign fifo_clr   = ((state == IDLE) && start_rise) || (busy && !start) || ovf_hit;
  assign push_keep  = (flush_push && !pend) ? part_keep : '1;
  assign count_inc  = (byte_count == '1) ? byte_count : byte_count + 32'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else if (fifo_clr) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= {flush_push, push_keep, acc};
  end

  assign head           = mem[rptr];
  assign strm.out_valid = !fifo_empty;
  assign strm.out_data  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign strm.out_keep  = fifo_empty ? '0 : head[DATA_W +: NB];
  assign strm.out_last  = !fifo_empty && head[EW-1];

  assign busy        = (state == RUN) || (state == FLUSH);
  assign done        = (state == DONE);
  assign overflow    = (state == ERR);
  assign reader_rstn = busy;

`ifdef SFS_SUM_EN
  logic [31:0] sum_acc;
  assign sum = sum_acc;
`else
  assign sum = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      byte_count <= '0;
      idle_cnt   <= '0;
      acc        <= '0;
      lane       <= '0;
      pend       <= 1'b0;
      tail_done  <= 1'b0;
`ifdef SFS_SUM_EN
      sum_acc    <= '0;
`endif
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state      <= RUN;
            byte_count <= '0;
            idle_cnt   <= '0;
            acc        <= '0;
            lane       <= '0;
            pend       <= 1'b0;
            tail_done  <= 1'b0;
`ifdef SFS_SUM_EN
            sum_acc    <= '0;
`endif
          end
        end
        RUN: begin
          if (!start) begin
            state <= IDLE;
            acc   <= '0;
            lane  <= '0;
            pend  <= 1'b0;
          end else if (accept) begin
            byte_count <= count_inc;
            idle_cnt   <= '0;
            // lane 0 opens a fresh word, so stale upper lanes are dropped here
            acc  <= ((lane == '0) ? '0 : acc) | (DATA_W'(strm.in_byte) << (8 * int'(lane)));
            pend <= (int'(lane) == NB - 1);
            lane <= (int'(lane) == NB - 1) ? '0 : lane + 1'b1;
`ifdef SFS_SUM_EN
            sum_acc <= sum_acc + {24'd0, strm.in_byte};
`endif
            if (ovf_hit)
              state <= ERR;
            else if ((MAX_BYTES != 0) && (count_inc == 32'(MAX_BYTES)))
              state <= FLUSH;
          end else if (byte_count != '0) begin
            idle_cnt <= idle_cnt + 32'd1;
            if (idle_cnt + 32'd1 >= 32'(IDLE_TIMEOUT))
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!start) begin
            state <= IDLE;
            acc   <= '0;
            lane  <= '0;
            pend  <= 1'b0;
          end else if (flush_push) begin
            tail_done <= 1'b1;
            pend      <= 1'b0;
          end else if (!need_tail && fifo_empty) begin
            state <= DONE;
          end
        end
        DONE, ERR: begin
          if (!start)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_file_stream.sv
// tb/tb_sd_file_stream.sv - checks sd_file_stream: unlimited instance and a 5-byte-limit instance on shared stimulus
`timescale 1ns/1ps
module tb_sd_file_stream;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int DEPTH = 4;
  localparam int TMO = 8;
  localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2, S_DONE = 3, S_ERR = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic in_en = 1'b0;
  logic ready = 1'b0;
  logic [7:0] in_byte = 8'd0;
  logic checking = 1'b0;

  logic rr0, bsy0, dn0, ov0, rr1, bsy1, dn1, ov1;
  logic [31:0] bc0, sm0, bc1, sm1;

  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sd_file_stream_if #(.DATA_W(DW)) if0 ();
  sd_file_stream_if #(.DATA_W(DW)) if1 ();

  assign if0.in_en = in_en;
  assign if0.in_byte = in_byte;
  assign if0.out_ready = ready;
  assign if1.in_en = in_en;
  assign if1.in_byte = in_byte;
  assign if1.out_ready = ready;

  sd_file_stream #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TMO), .MAX_BYTES(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .reader_rstn(rr0), .file_found(1'b1), .strm(if0),
    .byte_count(bc0), .busy(bsy0), .done(dn0), .overflow(ov0), .sum(sm0)
  );
  sd_file_stream #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TMO), .MAX_BYTES(5)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .reader_rstn(rr1), .file_found(1'b1), .strm(if1),
    .byte_count(bc1), .busy(bsy1), .done(dn1), .overflow(ov1), .sum(sm1)
  );

  // Model: per read, the list of accepted bytes; words are derived from it by index
  int          lim [2] = '{0, 5};
  int          m_st [2];
  int          m_n [2];
  int          m_wr [2];
  int          m_rd [2];
  int          m_idle [2];
  int          m_tail [2];
  logic [31:0] m_sum [2];
  logic [7:0]  m_bytes [2][512];
  logic        m_sq;

  logic [36:0] cap0 [$];
  logic [36:0] cap1 [$];

  task automatic chk(input int i, input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL inst%0d %s: got %h expected %h at %0t", i, nm, act, exp, $time);
  endtask

  task automatic model_step(input int i);
    int occ;
    bit pop;
    occ = m_wr[i] - m_rd[i];
    pop = (occ > 0) && ready;
    case (m_st[i])
      S_IDLE: begin
        if (start && !m_sq) begin
          m_st[i] = S_RUN; m_n[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
          m_idle[i] = 0; m_tail[i] = 0; m_sum[i] = 0;
        end
      end
      S_RUN: begin
        if (!start) begin
          m_st[i] = S_IDLE; m_wr[i] = 0; m_rd[i] = 0;
        end else if (in_en) begin
          if (m_n[i] > 0 && m_n[i] % NB == 0) begin
            if (occ == DEPTH && !pop) m_st[i] = S_ERR;
            else m_wr[i]++;
          end
          if (pop) m_rd[i]++;
          m_bytes[i][m_n[i]] = in_byte;
          m_n[i]++;
          m_sum[i] = m_sum[i] + 32'(in_byte);
          m_idle[i] = 0;
          if (m_st[i] == S_ERR) begin
            m_wr[i] = 0; m_rd[i] = 0;
          end else if (lim[i] != 0 && m_n[i] == lim[i]) begin
            m_st[i] = S_FLUSH;
          end
        end else begin
          if (pop) m_rd[i]++;
          if (m_n[i] > 0) begin
            m_idle[i]++;
            if (m_idle[i] >= TMO) m_st[i] = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!start) begin
          m_st[i] = S_IDLE; m_wr[i] = 0; m_rd[i] = 0;
        end else begin
          if (m_tail[i] == 0 && m_n[i] > 0) begin
            if (occ < DEPTH) begin m_wr[i]++; m_tail[i] = 1; end
          end else if (occ == 0) begin
            m_st[i] = S_DONE;
          end
          if (pop) m_rd[i]++;
        end
      end
      default: if (!start) m_st[i] = S_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = S_IDLE; m_n[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
        m_idle[i] = 0; m_tail[i] = 0; m_sum[i] = 0;
      end
      m_sq = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
      m_sq = start;
    end
  end

  function automatic void exp_word(input int i, input int k, output logic [31:0] d,
                                   output logic [3:0] kp, output logic l);
    int nb;
    d = '0;
    nb = m_n[i] - NB * k;
    if (nb > NB) nb = NB;
    for (int b = 0; b < nb; b++) d[8*b +: 8] = m_bytes[i][NB*k + b];
    kp = 4'((1 << nb) - 1);
    l = (m_tail[i] != 0) && (k == (m_n[i] - 1) / NB);
  endfunction

  task automatic cmp_inst(input int i, input logic v, input logic [31:0] d, input logic [3:0] kp,
                          input logic l, input logic rr, input logic [31:0] bc, input logic bs,
                          input logic dn, input logic ov, input logic [31:0] sm);
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic        ev;
    logic        eb;
    logic [31:0] es;
    ev = (m_wr[i] > m_rd[i]);
    eb = (m_st[i] == S_RUN) || (m_st[i] == S_FLUSH);
`ifdef SFS_SUM_EN
    es = m_sum[i];
`else
    es = 32'd0;
`endif
    chk(i, "out_valid", 40'(v), 40'(ev));
    if (ev) begin
      exp_word(i, m_rd[i], ed, ek, el);
      chk(i, "out_data", 40'(d), 40'(ed));
      chk(i, "out_keep", 40'(kp), 40'(ek));
      chk(i, "out_last", 40'(l), 40'(el));
    end
    chk(i, "byte_count", 40'(bc), 40'(m_n[i]));
    chk(i, "busy", 40'(bs), 40'(eb));
    chk(i, "reader_rstn", 40'(rr), 40'(eb));
    chk(i, "done", 40'(dn), 40'(m_st[i] == S_DONE));
    chk(i, "overflow", 40'(ov), 40'(m_st[i] == S_ERR));
    chk(i, "sum", 40'(sm), 40'(es));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp_inst(0, if0.out_valid, if0.out_data, if0.out_keep, if0.out_last, rr0, bc0, bsy0, dn0, ov0, sm0);
      cmp_inst(1, if1.out_valid, if1.out_data, if1.out_keep, if1.out_last, rr1, bc1, bsy1, dn1, ov1, sm1);
      if (if0.out_valid && ready) cap0.push_back({if0.out_last, if0.out_keep, if0.out_data});
      if (if1.out_valid && ready) cap1.push_back({if1.out_last, if1.out_keep, if1.out_data});
    end
  end

  function automatic logic [39:0] cap_at(input int i, input int k);
    if (i == 0) return (k < cap0.size()) ? 40'(cap0[k]) : '1;
    return (k < cap1.size()) ? 40'(cap1[k]) : '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    for (int b = 0; b < n; b++) begin
      in_en = 1'b1;
      in_byte = first + 8'(b);
      tick();
    end
    in_en = 1'b0;
  endtask

  task automatic wait_done(input int i, input int max_cyc);
    int c;
    c = 0;
    while (!(i == 0 ? dn0 : dn1) && c < max_cyc) begin
      tick();
      c++;
    end
    chk(i, "done_wait", 40'(i == 0 ? dn0 : dn1), 40'd1);
  endtask

  task automatic finish_read();
    start = 1'b0;
    tick();
    tick();
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lasts;
    tick(); tick(); tick();
    chk(0, "rst_reader_rstn", 40'(rr0), 40'd0);
    chk(0, "rst_byte_count", 40'(bc0), 40'd0);
    chk(0, "rst_busy", 40'(bsy0), 40'd0);
    chk(0, "rst_done", 40'(dn0), 40'd0);
    chk(0, "rst_overflow", 40'(ov0), 40'd0);
    chk(0, "rst_out_valid", 40'(if0.out_valid), 40'd0);
    chk(0, "rst_out_data", 40'(if0.out_data), 40'd0);
    chk(0, "rst_out_keep", 40'(if0.out_keep), 40'd0);
    chk(0, "rst_out_last", 40'(if0.out_last), 40'd0);
    chk(0, "rst_sum", 40'(sm0), 40'd0);
    rstn = 1'b1;
    checking = 1'b1;
    tick();

    // bytes 01..0A, idle timeout ends the file; limited instance stops after 5
    ready = 1'b1;
    start = 1'b1;
    tick();
    send_seq(8'h01, 10);
    chk(1, "limit_flushed_early", 40'(dn1), 40'd1);
    chk(0, "unlimited_still_busy", 40'(bsy0), 40'd1);
    wait_done(0, 100);
    chk(0, "t1_words", 40'(cap0.size()), 40'd3);
    chk(0, "t1_w0", cap_at(0, 0), {3'd0, 1'b0, 4'hF, 32'h04030201});
    chk(0, "t1_w1", cap_at(0, 1), {3'd0, 1'b0, 4'hF, 32'h08070605});
    chk(0, "t1_w2", cap_at(0, 2), {3'd0, 1'b1, 4'h3, 32'h00000A09});
    chk(0, "t1_byte_count", 40'(bc0), 40'd10);
    chk(1, "t4_words", 40'(cap1.size()), 40'd2);
    chk(1, "t4_w0", cap_at(1, 0), {3'd0, 1'b0, 4'hF, 32'h04030201});
    chk(1, "t4_w1", cap_at(1, 1), {3'd0, 1'b1, 4'h1, 32'h00000005});
    chk(1, "t4_byte_count", 40'(bc1), 40'd5);
    finish_read();

    // exact multiple of the word size
    start = 1'b1;
    tick();
    send_seq(8'h11, 8);
    wait_done(0, 100);
    chk(0, "t2_words", 40'(cap0.size()), 40'd2);
    chk(0, "t2_w0", cap_at(0, 0), {3'd0, 1'b0, 4'hF, 32'h14131211});
    chk(0, "t2_w1", cap_at(0, 1), {3'd0, 1'b1, 4'hF, 32'h18171615});
    finish_read();

    // consumer stalled: overflow
    ready = 1'b0;
    start = 1'b1;
    tick();
    send_seq(8'h30, 4 * (DEPTH + 1) + 1);
    tick();
    chk(0, "t3_overflow", 40'(ov0), 40'd1);
    chk(0, "t3_out_valid", 40'(if0.out_valid), 40'd0);
    chk(0, "t3_reader_rstn", 40'(rr0), 40'd0);
    start = 1'b0;
    tick();
    chk(0, "t3_idle_overflow", 40'(ov0), 40'd0);
    chk(0, "t3_idle_done", 40'(dn0), 40'd0);
    chk(0, "t3_idle_busy", 40'(bsy0), 40'd0);
    ready = 1'b1;
    finish_read();

    // abort after 6 bytes, then a clean restart
    start = 1'b1;
    tick();
    send_seq(8'h40, 6);
    start = 1'b0;
    tick();
    chk(0, "t5_abort_busy", 40'(bsy0), 40'd0);
    chk(0, "t5_abort_valid", 40'(if0.out_valid), 40'd0);
    lasts = 0;
    foreach (cap0[k]) if (cap0[k][36]) lasts++;
    chk(0, "t5_no_last", 40'(lasts), 40'd0);
    cap0.delete();
    cap1.delete();
    tick();
    start = 1'b1;
    tick();
    send_seq(8'h21, 4);
    wait_done(0, 100);
    chk(0, "t5_words", 40'(cap0.size()), 40'd1);
    chk(0, "t5_w0", cap_at(0, 0), {3'd0, 1'b1, 4'hF, 32'h24232221});
    chk(0, "t5_byte_count", 40'(bc0), 40'd4);
    finish_read();

    // 300 x FF with a random consumer
    start = 1'b1;
    tick();
    for (int b = 0; b < 300; b++) begin
      in_en = 1'b1;
      in_byte = 8'hFF;
      ready = ($urandom_range(0, 3) != 0);
      tick();
      in_en = 1'b0;
      ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ready = 1'b1;
    wait_done(0, 200);
    chk(0, "t6_byte_count", 40'(bc0), 40'd300);
`ifdef SFS_SUM_EN
    chk(0, "t6_sum", 40'(sm0), 40'h0000012AD4);
`else
    chk(0, "t6_sum", 40'(sm0), 40'd0);
`endif
    chk(0, "t6_words", 40'(cap0.size()), 40'd75);
    finish_read();

    // asynchronous reset mid-read
    start = 1'b1;
    tick();
    send_seq(8'h50, 3);
    #2;
    rstn = 1'b0;
    #1;
    chk(0, "arst_reader_rstn", 40'(rr0), 40'd0);
    chk(0, "arst_byte_count", 40'(bc0), 40'd0);
    chk(0, "arst_busy", 40'(bsy0), 40'd0);
    start = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    tick();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
